// File: rtl/tc_timer_pkg.sv
// Shared definitions for the tc_timer memory-mapped countdown timer:
// register offsets, CTRL field layout, mode encodings and FSM states.
package tc_timer_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] PRESET_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF  = 4'h8;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // Packed so the field order matches the CTRL bit positions above.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer on the CPU data port: CTRL/PRESET/COUNT
// registers, combinational read-back and a one-shot/auto-reload IRQ source.
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [29:0] BASE_WORD = BASE[31:2];

  ctrl_t       ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irqf_q;
  state_t      state_q;
  state_t      state_d;

  logic sel_ctrl, sel_preset, sel_count;
  logic full_word;
  logic ctrl_we, preset_we;
  logic load_count, dec_count, set_irqf, clr_irqf_reload, clr_en;
  logic oneshot;

  // Byte offset within the word plays no part in decode.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = addr[1:0];

  assign sel_ctrl   = (addr[31:2] == BASE_WORD + 30'(CTRL_OFF >> 2));
  assign sel_preset = (addr[31:2] == BASE_WORD + 30'(PRESET_OFF >> 2));
  assign sel_count  = (addr[31:2] == BASE_WORD + 30'(COUNT_OFF >> 2));
  assign full_word  = (byteen == 4'b1111);

  // COUNT is read-only, so only CTRL and PRESET have write strobes.
  assign ctrl_we   = sel_ctrl & full_word;
  assign preset_we = sel_preset & full_word;

  assign oneshot = (ctrl_q.mode != MODE_RELOAD);

  always_comb begin
    rdata = '0;
    if (sel_ctrl)        rdata = {28'd0, ctrl_q};
    else if (sel_preset) rdata = preset_q;
    else if (sel_count)  rdata = count_q;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d         = state_q;
    load_count      = 1'b0;
    dec_count       = 1'b0;
    set_irqf        = 1'b0;
    clr_irqf_reload = 1'b0;
    clr_en          = 1'b0;
    unique case (state_q)
      S_IDLE: if (ctrl_q.en) state_d = S_LOAD;
      S_LOAD: begin
        load_count = 1'b1;
        state_d    = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q.en) begin
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          set_irqf = 1'b1;
          state_d  = S_INT;
        end else begin
          dec_count = 1'b1;
        end
      end
      S_INT: begin
        if (oneshot) begin
          clr_en  = 1'b1;
          state_d = S_IDLE;
        end else begin
          clr_irqf_reload = 1'b1;
          state_d         = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irqf_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // A CPU write to CTRL takes priority over the one-shot EN clear.
      if (ctrl_we)     ctrl_q    <= ctrl_t'(wdata[3:0]);
      else if (clr_en) ctrl_q.en <= 1'b0;

      if (preset_we) preset_q <= wdata;

      if (load_count)     count_q <= preset_q;
      else if (dec_count) count_q <= count_q - 32'd1;

      // An expiry on the same edge as a CTRL write is not lost.
      if (set_irqf)                                 irqf_q <= 1'b1;
      else if (clr_irqf_reload || (ctrl_we && oneshot)) irqf_q <= 1'b0;
    end
  end

  assign irq = ctrl_q.im & irqf_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer: register access rules,
// one-shot and auto-reload timing, EN clear mid-count and reset abort.
module tb_tc_timer;
  import tc_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  tc_timer #(.BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    addr   = 32'h0;
    byteen = 4'h0;
    wdata  = 32'h0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
    addr   = BASE + {28'd0, off};
    byteen = be;
    wdata  = d;
    tick(1);
    bus_idle();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] off, input logic [31:0] exp);
    addr   = BASE + {28'd0, off};
    byteen = 4'h0;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    logic [31:0] reload_count [16];
    logic        reload_irq   [16];
    reload_count = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1,
                     32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    reload_irq   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    bus_idle();
    tick(2);
    reset = 1'b0;

    // Reset state
    check_reg("rst_ctrl", CTRL_OFF, 32'h0);
    check_reg("rst_preset", PRESET_OFF, 32'h0);
    check_reg("rst_count", COUNT_OFF, 32'h0);
    check_irq("rst_irq", 1'b0);

    // Partial-byte write is dropped
    wr(PRESET_OFF, 32'd5, 4'b0011);
    check_reg("partial_preset", PRESET_OFF, 32'h0);

    // One-shot, PRESET=3: irq at write edge + 6
    wr(PRESET_OFF, 32'd3, 4'hF);
    wr(CTRL_OFF, 32'h9, 4'hF);
    tick(2);
    check_reg("os_count_e2", COUNT_OFF, 32'd3);
    check_irq("os_irq_e2", 1'b0);
    tick(3);
    check_reg("os_count_e5", COUNT_OFF, 32'd0);
    check_irq("os_irq_e5", 1'b0);
    tick(1);
    check_irq("os_irq_e6", 1'b1);
    tick(1);
    check_reg("os_ctrl_e7", CTRL_OFF, 32'h8);
    check_irq("os_irq_e7", 1'b1);
    tick(3);
    check_irq("os_irq_hold", 1'b1);
    wr(CTRL_OFF, 32'h8, 4'hF);
    check_irq("os_irq_clear", 1'b0);

    // Auto-reload, PRESET=2: period 5, single-cycle irq
    wr(PRESET_OFF, 32'd2, 4'hF);
    wr(CTRL_OFF, 32'hB, 4'hF);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      check_reg($sformatf("ar_count_e%0d", k + 1), COUNT_OFF, reload_count[k]);
      check_irq($sformatf("ar_irq_e%0d", k + 1), reload_irq[k]);
    end
    wr(CTRL_OFF, 32'h8, 4'hF);
    tick(2);

    // EN cleared mid-count freezes COUNT one below the value seen at the write
    wr(PRESET_OFF, 32'd10, 4'hF);
    wr(CTRL_OFF, 32'h9, 4'hF);
    tick(6);
    check_reg("stop_count_at_write", COUNT_OFF, 32'd6);
    wr(CTRL_OFF, 32'h8, 4'hF);
    check_reg("stop_count_w", COUNT_OFF, 32'd5);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check_irq($sformatf("stop_irq_%0d", k), 1'b0);
    end
    check_reg("stop_count_frozen", COUNT_OFF, 32'd5);
    check_reg("stop_ctrl", CTRL_OFF, 32'h8);
    wr(CTRL_OFF, 32'h9, 4'hF);
    tick(1);
    check_reg("restart_count_e1", COUNT_OFF, 32'd5);
    tick(1);
    check_reg("restart_count_e2", COUNT_OFF, 32'd10);
    wr(CTRL_OFF, 32'h8, 4'hF);
    tick(2);

    // PRESET=0 with IM=0: expiry is masked, then cleared by the next CTRL write
    wr(PRESET_OFF, 32'd0, 4'hF);
    wr(CTRL_OFF, 32'h1, 4'hF);
    tick(3);
    check_reg("mask_ctrl_e3", CTRL_OFF, 32'h1);
    check_irq("mask_irq_e3", 1'b0);
    tick(1);
    check_reg("mask_ctrl_e4", CTRL_OFF, 32'h0);
    tick(2);
    wr(CTRL_OFF, 32'h9, 4'hF);
    check_irq("unmask_irq_e0", 1'b0);
    tick(1);
    check_irq("unmask_irq_e1", 1'b0);
    tick(1);
    check_irq("unmask_irq_e2", 1'b0);
    tick(1);
    check_irq("unmask_irq_e3", 1'b1);
    wr(CTRL_OFF, 32'h0, 4'hF);
    check_irq("unmask_irq_clr", 1'b0);

    // Read in the same cycle as a write returns the old value
    wr(PRESET_OFF, 32'd4, 4'hF);
    wr(CTRL_OFF, 32'hB, 4'hF);
    tick(3);
    addr   = BASE + {28'd0, PRESET_OFF};
    byteen = 4'hF;
    wdata  = 32'd7;
    #1;
    check("rw_same_cycle", rdata, 32'd4);
    tick(1);
    bus_idle();
    check_reg("rw_new_value", PRESET_OFF, 32'd7);

    // Reset mid-count in auto-reload mode
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_reg("mid_rst_ctrl", CTRL_OFF, 32'h0);
    check_reg("mid_rst_preset", PRESET_OFF, 32'h0);
    check_reg("mid_rst_count", COUNT_OFF, 32'h0);
    check_irq("mid_rst_irq", 1'b0);

    // COUNT and unmapped writes are ignored; unmapped reads return 0
    wr(COUNT_OFF, 32'h55, 4'hF);
    check_reg("count_ro", COUNT_OFF, 32'h0);
    wr(4'hC, 32'h77, 4'hF);
    check_reg("unmapped_read", 4'hC, 32'h0);
    check_reg("unmapped_ctrl", CTRL_OFF, 32'h0);
    check_reg("unmapped_preset", PRESET_OFF, 32'h0);
    tick(4);
    check_reg("idle_count", COUNT_OFF, 32'h0);
    check_irq("idle_irq", 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
